// File: rtl/rx_phase_slicer.sv
// rx_phase_slicer: estimates the best of four sampling phases from per-phase
// energy over a window of symbols, then decimates the 4x stream at that phase and slices it.
module rx_phase_slicer #(
  parameter int NB_INPUT = 8,
  parameter int LOG2_WIN = 10
) (
  input  logic                       clock,
  input  logic                       i_reset,
  input  logic                       i_enable,
  input  logic                       i_valid,
  input  logic signed [NB_INPUT-1:0] i_data,
  input  logic                       i_auto,
  input  logic        [1:0]          i_phase_sel,
  output logic                       o_data,
  output logic                       o_valid,
  output logic        [1:0]          o_phase,
  output logic                       o_phase_valid
);

  localparam int NB_MAG = NB_INPUT - 1;
  localparam int NB_ACC = NB_INPUT - 1 + LOG2_WIN;
  localparam logic [NB_INPUT-1:0] MOST_NEG = {1'b1, {(NB_INPUT-1){1'b0}}};
  localparam logic [NB_MAG-1:0]   MAG_ONE  = NB_MAG'(1);
  localparam logic [LOG2_WIN-1:0] SYM_ONE  = LOG2_WIN'(1);

  logic [NB_ACC-1:0]   r_acc [4];
  logic [1:0]          r_ph;
  logic [LOG2_WIN-1:0] r_sym;
  logic                r_data;
  logic                r_valid;
  logic [1:0]          r_phase;
  logic                r_phase_valid;

  logic                w_accept;
  logic                w_close;
  logic [1:0]          w_active;
  logic [NB_MAG-1:0]   w_neg;
  logic [NB_MAG-1:0]   w_mag;
  logic [NB_ACC-1:0]   w_mag_ext;
  logic [NB_ACC-1:0]   w_cand [4];
  logic [NB_ACC-1:0]   w_best_val;
  logic [1:0]          w_best;

  // A sample is consumed only when enabled and strobed; there is no backpressure,
  // and o_valid is a single-cycle strobe qualifying o_data on the cycle it is high.
  assign w_accept = i_enable & i_valid;
  assign w_close  = w_accept & (r_ph == 2'd3) & (&r_sym);
  assign w_active = i_auto ? r_phase : i_phase_sel;

  // Low bits of the two's-complement negation are exact for every negative value
  // except the most negative one, which saturates.
  assign w_neg = ~i_data[NB_MAG-1:0] + MAG_ONE;

  always_comb begin
    w_mag = i_data[NB_MAG-1:0];
    if (i_data == MOST_NEG)
      w_mag = '1;
    else if (i_data[NB_INPUT-1])
      w_mag = w_neg;
  end

  assign w_mag_ext = {{LOG2_WIN{1'b0}}, w_mag};

  // The closing sample belongs to phase 3, so it is folded into that candidate.
  always_comb begin
    w_cand[0] = r_acc[0];
    w_cand[1] = r_acc[1];
    w_cand[2] = r_acc[2];
    w_cand[3] = r_acc[3] + w_mag_ext;
    w_best     = 2'd0;
    w_best_val = w_cand[0];
    for (int k = 1; k < 4; k++) begin
      if (w_cand[k] > w_best_val) begin
        w_best_val = w_cand[k];
        w_best     = 2'(k);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (i_reset) begin
      for (int k = 0; k < 4; k++) r_acc[k] <= '0;
      r_ph          <= 2'd0;
      r_sym         <= '0;
      r_data        <= 1'b0;
      r_valid       <= 1'b0;
      r_phase       <= 2'd0;
      r_phase_valid <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (w_accept) begin
        r_ph <= r_ph + 2'd1;
        if (r_ph == 2'd3) r_sym <= r_sym + SYM_ONE;
        if (w_close) begin
          for (int k = 0; k < 4; k++) r_acc[k] <= '0;
          r_phase       <= w_best;
          r_phase_valid <= 1'b1;
        end else begin
          r_acc[r_ph] <= r_acc[r_ph] + w_mag_ext;
        end
        if (r_ph == w_active) begin
          r_data  <= i_data[NB_INPUT-1];
          r_valid <= 1'b1;
        end
      end
    end
  end

  assign o_data        = r_data;
  assign o_valid       = r_valid;
  assign o_phase       = r_phase;
  assign o_phase_valid = r_phase_valid;

endmodule

// File: tb/tb_rx_phase_slicer.sv
// Bench for rx_phase_slicer at LOG2_WIN=4: vector table, directed corner sequences
// and random traffic, all checked against a window-level reference model.
module tb_rx_phase_slicer;

  localparam int WIN = 16;
  localparam int WSAMP = 4 * WIN;

  logic              clock;
  logic              i_reset;
  logic              i_enable;
  logic              i_valid;
  logic signed [7:0] i_data;
  logic              i_auto;
  logic        [1:0] i_phase_sel;
  logic              o_data;
  logic              o_valid;
  logic        [1:0] o_phase;
  logic              o_phase_valid;

  rx_phase_slicer #(.NB_INPUT(8), .LOG2_WIN(4)) dut (
    .clock(clock), .i_reset(i_reset), .i_enable(i_enable), .i_valid(i_valid),
    .i_data(i_data), .i_auto(i_auto), .i_phase_sel(i_phase_sel),
    .o_data(o_data), .o_valid(o_valid), .o_phase(o_phase), .o_phase_valid(o_phase_valid)
  );

  // clock / reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_err = 0;
  int n_checks = 0;

  // scoreboard and reference model state
  logic [0:0] exp_q[$];
  logic       rec_q[$];
  logic       gap_q[$];
  bit         rec_on = 0;
  int         m_mags[$];
  int         m_ph = 0;
  int         m_phase = 0;
  int         m_pv = 0;
  int         m_data = 0;
  int         m_exp_v = 0;
  logic       g_auto = 1'b0;
  logic [1:0] g_sel = 2'd0;
  int         stream[WSAMP*2];

  function automatic void chk(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic int mag(int x);
    if (x < -127) return 127;
    return (x < 0) ? -x : x;
  endfunction

  function automatic void close_window();
    int sums[4];
    int best;
    sums = '{0, 0, 0, 0};
    foreach (m_mags[i]) sums[i % 4] += m_mags[i];
    best = 0;
    for (int p = 1; p < 4; p++) if (sums[p] > sums[best]) best = p;
    m_phase = best;
    m_pv = 1;
    m_mags.delete();
  endfunction

  // driver: one clock with the given inputs, model update, then output checks
  task automatic step(input logic en, input logic vld, input int d, input logic rst);
    int act;
    logic [0:0] e;
    i_reset = rst; i_enable = en; i_valid = vld; i_data = 8'(d);
    i_auto = g_auto; i_phase_sel = g_sel;
    @(posedge clock);
    m_exp_v = 0;
    if (rst) begin
      m_ph = 0; m_mags.delete(); m_phase = 0; m_pv = 0; m_data = 0; exp_q.delete();
    end else if (en && vld) begin
      act = g_auto ? m_phase : int'(g_sel);
      if (m_ph == act) begin
        m_exp_v = 1;
        m_data = (d < 0) ? 1 : 0;
        exp_q.push_back(1'(m_data));
      end
      m_mags.push_back(mag(d));
      if (m_mags.size() == WSAMP) close_window();
      m_ph = (m_ph + 1) % 4;
    end
    #1;
    chk("o_valid", o_valid, m_exp_v);
    if (o_valid) begin
      if (exp_q.size() == 0) chk("unexpected_decision", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("o_data", o_data, e);
      end
      if (rec_on) rec_q.push_back(o_data);
    end else begin
      chk("o_data_hold", o_data, m_data);
    end
    chk("o_phase", o_phase, m_phase);
    chk("o_phase_valid", o_phase_valid, m_pv);
  endtask

  typedef struct {
    int   d;
    logic ev;
    logic ed;
  } vec_t;
  vec_t vecs[16];

  initial begin
    i_reset = 1'b1; i_enable = 1'b0; i_valid = 1'b0; i_data = '0;
    i_auto = 1'b0; i_phase_sel = 2'd0;

    // vector table: manual phase 2, +100/-100 alternating on phase 2
    for (int i = 0; i < 16; i++) begin
      vecs[i].d  = (i % 4 != 2) ? 0 : (((i / 4) % 2) ? -100 : 100);
      vecs[i].ev = (i % 4 == 2);
      vecs[i].ed = ((i / 4) % 2) ? 1'b1 : 1'b0;
    end

    // reset, with enable and valid also high to check reset priority
    step(1, 1, -5, 1);
    step(1, 1, -5, 1);
    chk("reset_o_valid", o_valid, 0);
    chk("reset_o_phase_valid", o_phase_valid, 0);

    g_auto = 0; g_sel = 2'd2;
    for (int i = 0; i < 16; i++) begin
      step(1, 1, vecs[i].d, 0);
      chk("tbl_valid", o_valid, vecs[i].ev);
      if (vecs[i].ev) chk("tbl_data", o_data, vecs[i].ed);
    end

    // auto estimate, gapless
    for (int i = 0; i < WSAMP * 2; i++) begin
      int s;
      s = ($urandom_range(0, 1) == 1) ? 1 : -1;
      stream[i] = s * ((i % 4 == 1) ? 120 : 10);
    end
    step(0, 0, 0, 1);
    g_auto = 1; rec_q.delete(); rec_on = 1;
    for (int i = 0; i < WSAMP * 2; i++) begin
      step(1, 1, stream[i], 0);
      if (i == 60) chk("auto_pre_ph0_dec", o_valid, 1);
      if (i == 62) chk("auto_pre_pv", o_phase_valid, 0);
      if (i == 63) begin
        chk("auto_phase", o_phase, 1);
        chk("auto_pv", o_phase_valid, 1);
      end
      if (i == 64) chk("auto_post_ph0_nodec", o_valid, 0);
      if (i == 65) chk("auto_post_ph1_dec", o_valid, 1);
    end
    rec_on = 0;
    gap_q = rec_q;

    // same stream with enable/valid gaps
    step(0, 0, 0, 1);
    rec_q.delete(); rec_on = 1;
    for (int i = 0; i < WSAMP * 2; i++) begin
      int ng;
      ng = $urandom_range(0, 2);
      for (int g = 0; g < ng; g++) begin
        if ($urandom_range(0, 1) == 1) step(0, $urandom_range(0, 1), $urandom_range(0, 255) - 128, 0);
        else step(1, 0, $urandom_range(0, 255) - 128, 0);
      end
      step(1, 1, stream[i], 0);
    end
    rec_on = 0;
    chk("gap_dec_count", rec_q.size(), gap_q.size());
    for (int i = 0; i < rec_q.size() && i < gap_q.size(); i++) chk("gap_bit", rec_q[i], gap_q[i]);
    chk("gap_phase", o_phase, 1);

    // tie and saturation
    step(0, 0, 0, 1);
    for (int i = 0; i < WSAMP; i++) step(1, 1, (i % 4 == 3) ? -128 : 127, 0);
    chk("tie_phase", o_phase, 0);
    chk("tie_pv", o_phase_valid, 1);
    for (int i = 0; i < WSAMP; i++) step(1, 1, (i % 4 == 3) ? -127 : 126, 0);
    chk("sat_phase", o_phase, 3);

    // reset mid-window
    step(0, 0, 0, 1);
    for (int i = 0; i < 40; i++) step(1, 1, $urandom_range(0, 255) - 128, 0);
    step(1, 1, 77, 1);
    chk("midrst_valid", o_valid, 0);
    chk("midrst_data", o_data, 0);
    chk("midrst_phase", o_phase, 0);
    for (int i = 0; i < WSAMP; i++) begin
      step(1, 1, stream[i], 0);
      if (i == 62) chk("midrst_pv_low", o_phase_valid, 0);
      if (i == 63) chk("midrst_pv_high", o_phase_valid, 1);
    end

    // live manual phase switch 0 -> 3
    step(0, 0, 0, 1);
    g_auto = 0; g_sel = 2'd0;
    for (int i = 0; i < 6; i++) step(1, 1, -50, 0);
    g_sel = 2'd3;
    step(1, 1, -50, 0);
    chk("switch_ph2_nodec", o_valid, 0);
    step(1, 1, -50, 0);
    chk("switch_ph3_dec", o_valid, 1);

    // random traffic
    for (int i = 0; i < 900; i++) begin
      if ($urandom_range(0, 40) == 0) g_auto = ~g_auto;
      if ($urandom_range(0, 30) == 0) g_sel = 2'($urandom_range(0, 3));
      step($urandom_range(0, 9) != 0, $urandom_range(0, 4) != 0,
           $urandom_range(0, 255) - 128, $urandom_range(0, 299) == 0);
    end

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
